// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM register bus for one GPIO bank: word-indexed, zero-wait-state,
// readdata combinational from address.
interface avalon_pio_irq_if;
  logic [2:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_irq.sv
// GPIO bank with per-bit direction, atomic set/clear, synchronised inputs,
// selectable rising/falling edge capture and a maskable level interrupt.
module avalon_pio_irq #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RESET_OUT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  avalon_pio_irq_if.slave   bus,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGE    = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_EDGESEL = 3'd6,
    ADDR_RSVD    = 3'd7
  } addr_e;

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == WARM_DONE) ? v : v + 3'd1;
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] sel_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_q;

  addr_e            addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] edge_d;
  logic             cap_en;
  logic [31:0]      rdata;

  // The read strobe has no side effects and upper writedata bits are ignored.
  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.writedata};

  assign addr  = addr_e'(bus.address);
  assign wdata = bus.writedata[WIDTH-1:0];

  // Input synchroniser stage p0..pN-1, then prev one clock behind in_sync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_p[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_q <= in_sync;
      warm_q <= sat_inc(warm_q);
    end
  end

  assign in_sync = sync_p[SYNC_STAGES-1];
  // Suppress capture until the chain holds only post-reset samples.
  assign cap_en  = (warm_q == WARM_DONE);
  assign cond    = (sel_q & ~in_sync & prev_q) | (~sel_q & in_sync & ~prev_q);
  assign w1c     = (bus.write && addr == ADDR_EDGE) ? wdata : '0;
  // A new edge outranks a same-cycle clear of the same bit.
  assign edge_d  = (edge_q & ~w1c) | (cap_en ? cond : '0);

  always_comb begin
    out_d = out_q;
    if (bus.write) begin
      case (addr)
        ADDR_DATA:   out_d = wdata;
        ADDR_OUTSET: out_d = out_q | wdata;
        ADDR_OUTCLR: out_d = out_q & ~wdata;
        default:     out_d = out_q;
      endcase
    end
  end

  // Register file update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_OUT;
      dir_q  <= '0;
      mask_q <= '0;
      sel_q  <= '0;
      edge_q <= '0;
    end else begin
      out_q  <= out_d;
      edge_q <= edge_d;
      if (bus.write && addr == ADDR_DIR)     dir_q  <= wdata;
      if (bus.write && addr == ADDR_IRQMASK) mask_q <= wdata;
      if (bus.write && addr == ADDR_EDGESEL) sel_q  <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:    rdata = zext((dir_q & out_q) | (~dir_q & in_sync));
      ADDR_DIR:     rdata = zext(dir_q);
      ADDR_IRQMASK: rdata = zext(mask_q);
      ADDR_EDGE:    rdata = zext(edge_q);
      ADDR_EDGESEL: rdata = zext(sel_q);
      ADDR_OUTSET, ADDR_OUTCLR, ADDR_RSVD: rdata = '0;
      default:      rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign gpio_out     = out_q;
  assign gpio_oe      = dir_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Bench for avalon_pio_irq: directed scenarios plus randomized bus/pin
// traffic compared against a history-based reference model.
module tb_avalon_pio_irq;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  avalon_pio_irq_if bus ();

  avalon_pio_irq #(.WIDTH(W), .SYNC_STAGES(S), .RESET_OUT('0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus the pin value seen at each clock
  // since reset; the synchronised view is simply that history delayed.
  logic [W-1:0] m_out, m_dir, m_mask, m_sel, m_edge;
  logic [W-1:0] hist[$];
  int           n;

  function automatic logic [W-1:0] hist_at(input int k);
    if (k < 1) return '0;
    return hist[k-1];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [W-1:0] ins;
    ins = hist_at(n - S + 1);
    case (a)
      3'd0: return {24'b0, (m_dir & m_out) | (~m_dir & ins)};
      3'd1: return {24'b0, m_dir};
      3'd2: return {24'b0, m_mask};
      3'd3: return {24'b0, m_edge};
      3'd6: return {24'b0, m_sel};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_mask = '0; m_sel = '0; m_edge = '0;
    hist.delete();
    n = 0;
  endtask

  task automatic tick();
    logic [W-1:0] ins, prv, nedge, clr, d;
    @(posedge clk);
    n++;
    hist.push_back(gpio_in);
    ins   = hist_at(n - S);
    prv   = hist_at(n - S - 1);
    nedge = (m_sel & ~ins & prv) | (~m_sel & ins & ~prv);
    if (n - 1 < S + 1) nedge = '0;
    clr = '0;
    d   = bus.writedata[W-1:0];
    if (bus.write) begin
      case (bus.address)
        3'd0: m_out  = d;
        3'd1: m_dir  = d;
        3'd2: m_mask = d;
        3'd3: clr    = d;
        3'd4: m_out  = m_out | d;
        3'd5: m_out  = m_out & ~d;
        3'd6: m_sel  = d;
        default: ;
      endcase
    end
    m_edge = (m_edge & ~clr) | nedge;
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.read = 1'b0;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic set_addr(input logic [2:0] a);
    bus.address = a; bus.read = 1'b1; bus.write = 1'b0;
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    gpio_in = '0;
    assert_reset();
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got %h expected 00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_gpio_oe got %h expected 00", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq); end
    release_reset();
    for (int a = 0; a < 8; a++) begin
      set_addr(3'(a));
      checks++;
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_read addr %0d got %h expected 00000000", a, bus.readdata); end
      tick();
    end
  endtask

  task automatic test_output();
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'hA5);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL data_write got %h expected a5", gpio_out); end
    checks++; if (gpio_oe !== 8'hFF) begin errors++; $display("FAIL dir_oe got %h expected ff", gpio_oe); end
    set_addr(3'd0);
    checks++; if (bus.readdata !== 32'hA5) begin errors++; $display("FAIL data_read got %h expected 000000a5", bus.readdata); end
    bus_write(3'd4, 32'h0A);
    checks++; if (gpio_out !== 8'hAF) begin errors++; $display("FAIL outset got %h expected af", gpio_out); end
    set_addr(3'd4);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL outset_read got %h expected 0", bus.readdata); end
    bus_write(3'd5, 32'h81);
    checks++; if (gpio_out !== 8'h2E) begin errors++; $display("FAIL outclr got %h expected 2e", gpio_out); end
    bus_write(3'd0, 32'hFFFFFF00);
    set_addr(3'd0);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL data_upper got %h expected 00000000", bus.readdata); end
    bus_write(3'd7, 32'hFF);
    set_addr(3'd7);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reserved got %h expected 0", bus.readdata); end
  endtask

  task automatic test_edge_rise();
    bus_write(3'd1, 32'h00);
    bus_write(3'd3, 32'hFF);
    gpio_in = 8'h01;
    tick(); tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL rise_early got %h expected 00", bus.readdata); end
    tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h01) begin errors++; $display("FAIL rise_latency got %h expected 01", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_masked_irq got %b expected 0", irq); end
    bus_write(3'd2, 32'h01);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq got %b expected 1", irq); end
    bus_write(3'd3, 32'h01);
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL w1c got %h expected 00", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b expected 0", irq); end
  endtask

  task automatic test_edgesel();
    bus_write(3'd6, 32'h02);
    gpio_in = 8'h03;
    tick();
    set_addr(3'd0);
    checks++; if (bus.readdata !== 32'h01) begin errors++; $display("FAIL sync_one_clk got %h expected 01", bus.readdata); end
    tick();
    set_addr(3'd0);
    checks++; if (bus.readdata !== 32'h03) begin errors++; $display("FAIL sync_two_clk got %h expected 03", bus.readdata); end
    tick(); tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL fall_sel_rise got %h expected 00", bus.readdata); end
    gpio_in = 8'h01;
    tick(); tick(); tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h02) begin errors++; $display("FAIL fall_capture got %h expected 02", bus.readdata); end
    bus_write(3'd3, 32'h02);
    gpio_in = 8'h03;
    repeat (4) tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL fall_ignores_rise got %h expected 00", bus.readdata); end
  endtask

  task automatic test_w1c_collision();
    bus_write(3'd6, 32'h00);
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL sel_change_no_edge got %h expected 00", bus.readdata); end
    bus_write(3'd2, 32'h04);
    gpio_in = 8'h07;
    tick(); tick(); tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h04) begin errors++; $display("FAIL bit2_capture got %h expected 04", bus.readdata); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL bit2_irq got %b expected 1", irq); end
    gpio_in = 8'h03;
    repeat (4) tick();
    gpio_in = 8'h07;
    tick(); tick();
    bus_write(3'd3, 32'h04);
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h04) begin errors++; $display("FAIL set_wins got %h expected 04", bus.readdata); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b expected 1", irq); end
    bus_write(3'd3, 32'h04);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got %b expected 0", irq); end
  endtask

  task automatic test_warmup_midreset();
    gpio_in = 8'hFF;
    assert_reset();
    release_reset();
    repeat (10) tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'h00) begin errors++; $display("FAIL warmup_spurious got %h expected 00", bus.readdata); end
    bus_write(3'd6, 32'hFF);
    gpio_in = 8'h00;
    tick(); tick(); tick();
    set_addr(3'd3);
    checks++; if (bus.readdata !== 32'hFF) begin errors++; $display("FAIL fall_all got %h expected ff", bus.readdata); end
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'hFF);
    bus_write(3'd4, 32'h3C);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b expected 1", irq); end
    assert_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b expected 0", irq); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midreset_out got %h expected 00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL midreset_oe got %h expected 00", gpio_oe); end
    for (int a = 0; a < 8; a++) begin
      set_addr(3'(a));
      checks++;
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL midreset_read addr %0d got %h expected 0", a, bus.readdata); end
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [2:0]  a;
      logic [31:0] exp_rd;
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      bus.address   = a;
      bus.write     = ($urandom_range(0, 3) == 0);
      bus.read      = !bus.write;
      bus.writedata = $urandom;
      #1;
      exp_rd = model_read(a);
      checks++; if (bus.readdata !== exp_rd) begin errors++; $display("FAIL rand_read cyc %0d addr %0d got %h expected %h", c, a, bus.readdata, exp_rd); end
      checks++; if (gpio_out !== m_out) begin errors++; $display("FAIL rand_out cyc %0d got %h expected %h", c, gpio_out, m_out); end
      checks++; if (gpio_oe !== m_dir) begin errors++; $display("FAIL rand_oe cyc %0d got %h expected %h", c, gpio_oe, m_dir); end
      checks++; if (irq !== |(m_edge & m_mask)) begin errors++; $display("FAIL rand_irq cyc %0d got %b expected %b", c, irq, |(m_edge & m_mask)); end
      tick();
    end
    bus.write = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    gpio_in       = '0;
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    model_reset();
    test_reset();
    test_output();
    test_edge_rise();
    test_edgesel();
    test_w1c_collision();
    test_warmup_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_irq.md
Name: avalon_pio_irq

Overview:
Parametrised Avalon-MM slave GPIO port: the next generation of the single 8-bit LED output register. Provides per-bit direction, atomic set/clear, synchronised inputs, per-bit rising/falling edge capture and a maskable level interrupt to the Nios II. Zero-wait-state slave on the system bus, one instance per GPIO bank.

Parameters:
WIDTH, 8, number of GPIO bits (1..32).
SYNC_STAGES, 2, input synchroniser depth (2..4).
RESET_OUT, 0, reset value of the output data register (WIDTH bits).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  3  word register index
read  input  1  Avalon read strobe
readdata  output  32  read data, combinational from address
write  input  1  Avalon write strobe
writedata  input  32  write data
gpio_in  input  WIDTH  asynchronous pin inputs
gpio_out  output  WIDTH  output data register
gpio_oe  output  WIDTH  output enable, 1 = drive pin
irq  output  1  level interrupt, active-high

Behaviour:
- Reset is asynchronous and active-high, clock is clk. Values at reset:
  - out = RESET_OUT.
  - dir, mask, edgesel and edge = 0.
  - Synchroniser and prev registers = 0.
  - Warm-up counter = 0.
  - irq = 0, gpio_oe = 0.
- Register map. Only bits [WIDTH-1:0] are significant. Upper writedata bits are ignored and upper readdata bits read 0.
  - 0 DATA: write loads out. Read returns per bit dir ? out : in_sync.
  - 1 DIR: read/write. 1 = output. gpio_oe = dir.
  - 2 IRQMASK: read/write.
  - 3 EDGE: read returns the capture register. Write-1-to-clear per bit.
  - 4 OUTSET: write does out |= writedata. Reads 0.
  - 5 OUTCLR: write does out &= ~writedata. Reads 0.
  - 6 EDGESEL: read/write per bit. 0 = rising, 1 = falling.
  - 7 reserved: writes ignored, reads 0.
- Writes take effect on the clk edge where write=1. Register outputs update in the following cycle.
- readdata is combinational from address. The read strobe has no side effects.
- A read and a write in the same cycle return the pre-write value.
- Input path:
  - gpio_in passes through a SYNC_STAGES flop chain; the last stage is in_sync.
  - prev is a register loaded from in_sync every clock.
  - Rising-edge condition: in_sync & ~prev. Falling-edge condition: ~in_sync & prev. EDGESEL selects one per bit.
- Edge capture:
  - A bit of edge is set on the clock after its selected condition is true.
  - Total latency from a gpio_in change to the edge bit set is SYNC_STAGES+1 clocks.
  - Capture is independent of dir and mask.
- Warm-up counter:
  - Counts 0 to SYNC_STAGES+1 after reset deassertion, then saturates.
  - Edge capture is suppressed until the counter saturates, so pins static-high at reset release produce no spurious edge.
- Simultaneous events:
  - An EDGE W1C and a new edge on the same bit in the same cycle leave the bit set (set wins).
  - A W1C has no effect on bits written 0.
  - A DATA write has priority over OUTSET/OUTCLR only by address exclusivity; one register is written per cycle.
- irq is combinational: |(edge & mask). It stays asserted until the bits are cleared or masked. Changing the mask affects irq in the cycle after the write.
- Reset mid-operation returns all state to the reset values immediately, irrespective of clk. Pending edges are lost.
- Changing EDGESEL does not set edge bits by itself; only the live condition on in_sync/prev sets them.

Test Plan:
- Reset -> gpio_out=RESET_OUT(0x00), gpio_oe=0x00, irq=0; reads of addresses 0..7 return 0 with gpio_in=0.
- DIR=0xFF, DATA=0xA5 -> gpio_out=0xA5, read DATA=0xA5. OUTSET 0x0A -> 0xAF. OUTCLR 0x81 -> 0x2E. Write 0xFFFFFF00 to DATA -> read 0x00000000.
- DIR=0, gpio_in bit0 0->1 -> EDGE=0x01 exactly 3 clocks later (SYNC_STAGES=2), irq=0. IRQMASK=0x01 -> irq=1 next cycle. Write EDGE=0x01 -> EDGE=0, irq=0.
- EDGESEL=0x02: gpio_in bit1 1->0 -> EDGE=0x02; bit1 0->1 -> no change. DATA read with dir=0 tracks gpio_in after 2 clocks.
- W1C EDGE=0x04 in the same cycle bit2 edge is captured -> EDGE bit2 remains 1, irq stays 1 with mask=0x04.
- gpio_in=0xFF held through reset release -> EDGE=0x00 after 10 clocks. Then gpio_in=0x00 with EDGESEL=0xFF -> EDGE=0xFF. Assert reset mid-run -> all registers 0 and irq=0 immediately.
